// File: rtl/disp_hex_mux.sv
// Four-digit common-anode seven-segment scanner: a free-running refresh counter
// selects one hex nibble at a time and drives active-low anodes and segments.
module disp_hex_mux #(
  parameter int unsigned N = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hex3,
  input  logic [3:0] hex2,
  input  logic [3:0] hex1,
  input  logic [3:0] hex0,
  input  logic [3:0] dp_in,
  output logic [3:0] an,
  output logic [7:0] sseg
);

  logic [N-1:0] cnt_q, cnt_d;
  logic [1:0]   sel;
  logic [3:0]   hex_val;
  logic         dp;
  logic [6:0]   seg;

  assign cnt_d = cnt_q + {{(N-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Top two counter bits pick the digit, so each digit holds for 2^(N-2) clocks.
  assign sel = cnt_q[N-1:N-2];

  always_comb begin
    an      = 4'b1110;
    hex_val = hex0;
    dp      = dp_in[0];
    unique case (sel)
      2'b00: begin an = 4'b1110; hex_val = hex0; dp = dp_in[0]; end
      2'b01: begin an = 4'b1101; hex_val = hex1; dp = dp_in[1]; end
      2'b10: begin an = 4'b1011; hex_val = hex2; dp = dp_in[2]; end
      2'b11: begin an = 4'b0111; hex_val = hex3; dp = dp_in[3]; end
    endcase
  end

  // Segment order {a,b,c,d,e,f,g}, low = lit.
  always_comb begin
    seg = 7'b1111111;
    unique case (hex_val)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'ha: seg = 7'b0001000;
      4'hb: seg = 7'b1100000;
      4'hc: seg = 7'b0110001;
      4'hd: seg = 7'b1000010;
      4'he: seg = 7'b0110000;
      4'hf: seg = 7'b0111000;
    endcase
  end

  assign sseg = {dp, seg};

endmodule

// File: tb/tb_disp_hex_mux.sv
// Directed bench for disp_hex_mux: a fast-scan (N=4) instance for sequencing
// and reset behaviour, and a default-width instance for the decode sweep.
module tb_disp_hex_mux;

  logic       clk;
  logic       reset, reset18;
  logic [3:0] hex3, hex2, hex1, hex0, dp_in;
  logic [3:0] hex0_18, dp18;
  logic [3:0] an, an18;
  logic [7:0] sseg, sseg18;

  int passed = 0;
  int total  = 0;
  int q      = 0;

  logic [6:0] dec_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] hex_cur [4];

  disp_hex_mux #(.N(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .hex3  (hex3),
    .hex2  (hex2),
    .hex1  (hex1),
    .hex0  (hex0),
    .dp_in (dp_in),
    .an    (an),
    .sseg  (sseg)
  );

  disp_hex_mux #(.N(18)) u_dut18 (
    .clk   (clk),
    .reset (reset18),
    .hex3  (4'h0),
    .hex2  (4'h0),
    .hex1  (4'h0),
    .hex0  (hex0_18),
    .dp_in (dp18),
    .an    (an18),
    .sseg  (sseg18)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    q = (q + 1) % 16;
  endtask

  // Expected outputs of the N=4 instance for the current model count q.
  task automatic check_digit(input string tag);
    int s;
    s = q / 4;
    hex_cur = '{hex0, hex1, hex2, hex3};
    check({tag, "_an"}, {4'b0, an}, {4'b0, an_tab[s]});
    check({tag, "_sseg"}, sseg, {dp_in[s], dec_tab[hex_cur[s]]});
  endtask

  initial begin
    reset   = 1'b1;
    reset18 = 1'b1;
    hex3 = 4'h1; hex2 = 4'h2; hex1 = 4'h3; hex0 = 4'h4;
    dp_in   = 4'hf;
    hex0_18 = 4'h0;
    dp18    = 4'hf;

    #2;
    check("rst_an", {4'b0, an}, 8'b0000_1110);
    check("rst_sseg", sseg, 8'b1_1001100);
    @(posedge clk);
    #1;
    check("rst_hold_an", {4'b0, an}, 8'b0000_1110);

    // Release and scan two full frames: 1110x4, 1101x4, 1011x4, 0111x4.
    reset = 1'b0;
    q = 0;
    check_digit("scan_q0");
    for (int k = 0; k < 32; k++) begin
      tick();
      check_digit($sformatf("scan_%0d", k + 1));
    end
    check("wrap_an", {4'b0, an}, 8'b0000_1110);

    // ABCD with mixed decimal points, one frame.
    hex3 = 4'ha; hex2 = 4'hb; hex1 = 4'hc; hex0 = 4'hd;
    dp_in = 4'b0101;
    #1;
    check_digit("dp_q0");
    for (int k = 0; k < 16; k++) begin
      tick();
      check_digit($sformatf("dp_%0d", k + 1));
    end

    // ABCD with all decimal points off: digit 0 shows d, digit 3 shows A.
    dp_in = 4'hf;
    #1;
    check("abcd_d", sseg, 8'b1_1000010);
    for (int k = 0; k < 12; k++) tick();
    check("abcd_an3", {4'b0, an}, 8'b0000_0111);
    check("abcd_a", sseg, 8'b1_0001000);
    for (int k = 0; k < 4; k++) tick();

    // Asynchronous reset in the middle of digit 2 (q = 9), between edges.
    for (int k = 0; k < 9; k++) tick();
    check("pre_rst_an", {4'b0, an}, 8'b0000_1011);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_an", {4'b0, an}, 8'b0000_1110);
    check("async_rst_sseg", sseg, 8'b1_1000010);
    @(posedge clk);
    #1;
    check("async_hold_an", {4'b0, an}, 8'b0000_1110);
    reset = 1'b0;
    q = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_digit($sformatf("resume_%0d", k + 1));
    end

    // Decode sweep on the default-width instance, still within digit 0.
    reset18 = 1'b0;
    for (int v = 0; v < 16; v++) begin
      hex0_18 = v[3:0];
      #1;
      check($sformatf("dec_%0h", v), sseg18, {1'b1, dec_tab[v]});
      check($sformatf("dec_an_%0h", v), {4'b0, an18}, 8'b0000_1110);
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
